note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_player_pkg.sv | 23 ++
 rtl/note_player_frequency_rom.sv | 82 ++++++++
 rtl/note_player.sv | 100 ++++++++++
 tb/tb_note_player.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared types and widths for the note player: FSM encoding, bus widths, rest code.
// Pure declarations; no timing or flow control of its own.
package note_player_pkg;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int PHASE_W = 22;
    localparam int STEP_W  = 20;
    localparam int ADDR_W  = 10;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic logic [PHASE_W-1:0] extend_step(input logic [STEP_W-1:0] s);
        return {{(PHASE_W - STEP_W){1'b0}}, s};
    endfunction

endpackage

// File: rtl/note_player_frequency_rom.sv
// Note index to phase step (Hz * 2^22 / 48 kHz, A0 = note 1, A4 = note 49); combinational.
// Zero latency, no flow control; entry 0 is the rest and yields a zero step.
module frequency_rom
    import note_player_pkg::*;
(
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);

    always_comb begin
        step = '0;
        case (note)
            6'd0:  step = 20'd0;
            6'd1:  step = 20'd2403;
            6'd2:  step = 20'd2546;
            6'd3:  step = 20'd2697;
            6'd4:  step = 20'd2858;
            6'd5:  step = 20'd3028;
            6'd6:  step = 20'd3208;
            6'd7:  step = 20'd3398;
            6'd8:  step = 20'd3600;
            6'd9:  step = 20'd3815;
            6'd10: step = 20'd4041;
            6'd11: step = 20'd4282;
            6'd12: step = 20'd4536;
            6'd13: step = 20'd4806;
            6'd14: step = 20'd5092;
            6'd15: step = 20'd5394;
            6'd16: step = 20'd5716;
            6'd17: step = 20'd6056;
            6'd18: step = 20'd6416;
            6'd19: step = 20'd6796;
            6'd20: step = 20'd7200;
            6'd21: step = 20'd7630;
            // each octave above is an exact doubling of the one below
            6'd22: step = 20'd8082;
            6'd23: step = 20'd8564;
            6'd24: step = 20'd9072;
            6'd25: step = 20'd9612;
            6'd26: step = 20'd10184;
            6'd27: step = 20'd10788;
            6'd28: step = 20'd11432;
            6'd29: step = 20'd12112;
            6'd30: step = 20'd12832;
            6'd31: step = 20'd13592;
            6'd32: step = 20'd14400;
            6'd33: step = 20'd15260;
            6'd34: step = 20'd16164;
            6'd35: step = 20'd17128;
            6'd36: step = 20'd18144;
            6'd37: step = 20'd19224;
            6'd38: step = 20'd20368;
            6'd39: step = 20'd21576;
            6'd40: step = 20'd22864;
            6'd41: step = 20'd24224;
            6'd42: step = 20'd25664;
            6'd43: step = 20'd27184;
            6'd44: step = 20'd28800;
            6'd45: step = 20'd30520;
            6'd46: step = 20'd32328;
            6'd47: step = 20'd34256;
            6'd48: step = 20'd36288;
            6'd49: step = 20'd38448;
            6'd50: step = 20'd40736;
            6'd51: step = 20'd43152;
            6'd52: step = 20'd45728;
            6'd53: step = 20'd48448;
            6'd54: step = 20'd51328;
            6'd55: step = 20'd54368;
            6'd56: step = 20'd57600;
            6'd57: step = 20'd61040;
            6'd58: step = 20'd64656;
            6'd59: step = 20'd68512;
            6'd60: step = 20'd72576;
            6'd61: step = 20'd76896;
            6'd62: step = 20'd81472;
            6'd63: step = 20'd86304;
            default: step = '0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// Plays one note: counts beats down to note_done, steps a wave-table phase per sample tick.
// note_done 1 cycle after the expiring beat, new_sample_ready 1 cycle after the tick; pause freezes all counting.
module note_player
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic              load_new_note,
    input  logic              beat,
    input  logic              generate_next_sample,
    output logic              note_done,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              new_sample_ready
);

    state_t              state, state_nxt;
    logic [DUR_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic [NOTE_W-1:0]   note_q;
    logic [DUR_W-1:0]    dur_q;
    logic [PHASE_W-1:0]  phase, phase_nxt;
    logic [STEP_W-1:0]   step;
    logic                run;
    logic                expire;

    frequency_rom u_rom (
        .note (note_q),
        .step (step)
    );

    assign run    = (state == PLAYING) && play_enable;
    // a latched zero length can never count down, so treat it as already expired
    assign expire = (beat_cnt <= DUR_W'(1)) || (dur_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        phase_nxt    = phase;
        if (load_new_note) begin
            // a load overrides any coincident beat and restarts the note
            state_nxt    = (duration == '0) ? DONE : PLAYING;
            beat_cnt_nxt = duration;
            phase_nxt    = '0;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                PLAYING: begin
                    if (play_enable && beat) begin
                        if (expire) begin
                            state_nxt    = DONE;
                            beat_cnt_nxt = '0;
                        end else begin
                            beat_cnt_nxt = beat_cnt - DUR_W'(1);
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
            if (note_q == NOTE_REST) begin
                phase_nxt = '0;
            end else if (run && generate_next_sample) begin
                phase_nxt = phase + extend_step(step);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt         <= '0;
            note_q           <= '0;
            dur_q            <= '0;
            phase            <= '0;
            new_sample_ready <= 1'b0;
        end else begin
            beat_cnt         <= beat_cnt_nxt;
            phase            <= phase_nxt;
            // rests still tick the sample path so downstream timing is unchanged
            new_sample_ready <= run && generate_next_sample;
            if (load_new_note) begin
                note_q <= note;
                dur_q  <= duration;
            end
        end
    end

    assign note_done   = (state == DONE);
    assign sample_addr = phase[PHASE_W-1 -: ADDR_W];

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: duration counting, pause, rest, load/beat collision, async reset.
module tb_note_player;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play_enable = 1'b0;
    logic [5:0] note = '0;
    logic [5:0] duration = '0;
    logic       load_new_note = 1'b0;
    logic       beat = 1'b0;
    logic       generate_next_sample = 1'b0;
    logic       note_done;
    logic [9:0] sample_addr;
    logic       new_sample_ready;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .note                 (note),
        .duration             (duration),
        .load_new_note        (load_new_note),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .note_done            (note_done),
        .sample_addr          (sample_addr),
        .new_sample_ready     (new_sample_ready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] n, input logic [5:0] d);
        note          = n;
        duration      = d;
        load_new_note = 1'b1;
        cyc();
        load_new_note = 1'b0;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        cyc();
        beat = 1'b0;
    endtask

    task automatic tick();
        generate_next_sample = 1'b1;
        cyc();
        generate_next_sample = 1'b0;
    endtask

    initial begin
        // reset state
        cyc();
        cyc();
        check("rst_done", note_done, 0);
        check("rst_addr", sample_addr, 0);
        check("rst_nsr", new_sample_ready, 0);
        reset       = 1'b1;
        play_enable = 1'b1;
        cyc();

        // note 20 (step 7200) for three beats
        load(6'd20, 6'd3);
        check("n20_load_done", note_done, 0);
        check("n20_load_addr", sample_addr, 0);
        tick();
        check("n20_t1_nsr", new_sample_ready, 1);
        check("n20_t1_addr", sample_addr, 1);
        cyc();
        check("n20_nsr_clear", new_sample_ready, 0);
        tick();
        check("n20_t2_addr", sample_addr, 3);
        do_beat();
        check("n20_b1", note_done, 0);
        do_beat();
        check("n20_b2", note_done, 0);
        do_beat();
        check("n20_b3_done", note_done, 1);
        cyc();
        check("n20_single_pulse", note_done, 0);
        tick();
        check("idle_nsr", new_sample_ready, 0);
        check("idle_addr_hold", sample_addr, 3);

        // zero duration goes straight to DONE
        load(6'd20, 6'd0);
        check("dur0_done", note_done, 1);
        check("dur0_addr", sample_addr, 0);
        cyc();
        check("dur0_after", note_done, 0);
        check("dur0_addr2", sample_addr, 0);

        // pause mid-note: beats and ticks are ignored
        load(6'd20, 6'd4);
        tick();
        check("pause_pre_addr", sample_addr, 1);
        do_beat();
        cyc();
        do_beat();
        cyc();
        play_enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            beat = 1'b1;
            generate_next_sample = 1'b1;
            cyc();
            beat = 1'b0;
            generate_next_sample = 1'b0;
            if (new_sample_ready) pulses++;
            if (note_done) pulses++;
        end
        check("pause_no_pulses", pulses, 0);
        check("pause_addr_frozen", sample_addr, 1);
        play_enable = 1'b1;
        do_beat();
        check("pause_b3", note_done, 0);
        cyc();
        do_beat();
        check("pause_b4_done", note_done, 1);
        cyc();
        check("pause_after", note_done, 0);

        // rest: sample ticks still pulse, address stays at zero
        load(6'd0, 6'd2);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (new_sample_ready) pulses++;
            check("rest_addr", sample_addr, 0);
            cyc();
            if (new_sample_ready) pulses++;
        end
        check("rest_nsr_count", pulses, 10);
        do_beat();
        check("rest_b1", note_done, 0);
        do_beat();
        check("rest_b2_done", note_done, 1);
        cyc();

        // load coincident with a beat restarts the count
        load(6'd20, 6'd2);
        do_beat();
        check("coll_b1", note_done, 0);
        note          = 6'd20;
        duration      = 6'd3;
        load_new_note = 1'b1;
        beat          = 1'b1;
        cyc();
        load_new_note = 1'b0;
        beat          = 1'b0;
        check("coll_load", note_done, 0);
        do_beat();
        check("coll_r1", note_done, 0);
        do_beat();
        check("coll_r2", note_done, 0);
        do_beat();
        check("coll_r3_done", note_done, 1);
        // load while in DONE: pulse already seen, next state PLAYING
        load(6'd20, 6'd1);
        check("done_load_playing", note_done, 0);
        do_beat();
        check("done_load_b1", note_done, 1);
        cyc();
        check("done_load_after", note_done, 0);

        // asynchronous reset mid-note
        load(6'd20, 6'd4);
        tick();
        check("arst_pre_addr1", sample_addr, 1);
        do_beat();
        do_beat();
        tick();
        check("arst_pre_nsr", new_sample_ready, 1);
        check("arst_pre_addr3", sample_addr, 3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_nsr", new_sample_ready, 0);
        check("arst_addr", sample_addr, 0);
        check("arst_done", note_done, 0);
        beat = 1'b1;
        cyc();
        cyc();
        beat = 1'b0;
        check("arst_hold_done", note_done, 0);
        reset = 1'b1;
        do_beat();
        check("arst_rel_b1", note_done, 0);
        do_beat();
        check("arst_rel_b2", note_done, 0);
        load(6'd20, 6'd1);
        check("arst_reload_addr", sample_addr, 0);
        tick();
        check("arst_reload_t1", sample_addr, 1);
        do_beat();
        check("arst_reload_done", note_done, 1);
        cyc();
        check("arst_reload_after", note_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
